// File: rtl/ysyx_23060184_ifu.sv
// Instruction fetch unit: takes one PC at a time, reads the instruction
// over an AXI-lite style read channel and hands it to decode.
module ysyx_23060184_ifu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] PC,
    input  logic                  Pvalid,
    output logic                  Iready,
    input  logic                  Branch,
    output logic [DATA_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [DATA_WIDTH-1:0] IPC,
    output logic                  Ifault,
    output logic                  Ivalid,
    input  logic                  Dready,
    output logic [DATA_WIDTH-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        OUT
    } state_t;

    state_t state;
    logic   kill;
    logic   kill_next;

    assign Iready    = (state == IDLE);
    assign kill_next = kill | Branch;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            Ivalid    <= 1'b0;
            Ifault    <= 1'b0;
            inst      <= '0;
            IPC       <= '0;
            araddr    <= '0;
            fetch_cnt <= '0;
            kill      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Pvalid && !Branch) begin
                        IPC    <= PC;
                        araddr <= PC;
                        if (PC[1:0] == 2'b00) begin
                            arvalid <= 1'b1;
                            state   <= AR;
                        end else begin
                            inst   <= '0;
                            Ifault <= 1'b1;
                            Ivalid <= 1'b1;
                            state  <= OUT;
                        end
                    end
                end
                AR: begin
                    // a redirect cannot retract arvalid, so remember it
                    kill <= kill_next;
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        kill   <= 1'b0;
                        if (kill_next) begin
                            state <= IDLE;
                        end else begin
                            inst   <= rdata;
                            Ifault <= (rresp != 2'b00);
                            Ivalid <= 1'b1;
                            state  <= OUT;
                        end
                    end else begin
                        kill <= kill_next;
                    end
                end
                OUT: begin
                    if (Branch) begin
                        Ivalid <= 1'b0;
                        state  <= IDLE;
                    end else if (Dready) begin
                        Ivalid    <= 1'b0;
                        fetch_cnt <= fetch_cnt + DATA_WIDTH'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060184_ifu.sv
// Directed bench for the fetch unit: handshakes, stalls, kills,
// faults and asynchronous reset.
module tb_ysyx_23060184_ifu;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] PC;
    logic        Pvalid;
    logic        Iready;
    logic        Branch;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] IPC;
    logic        Ifault;
    logic        Ivalid;
    logic        Dready;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_cnt = 0;

    ysyx_23060184_ifu #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .PC(PC), .Pvalid(Pvalid),
        .Iready(Iready), .Branch(Branch), .araddr(araddr),
        .arvalid(arvalid), .arready(arready), .rdata(rdata),
        .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .inst(inst), .IPC(IPC), .Ifault(Ifault), .Ivalid(Ivalid),
        .Dready(Dready), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    // advance one active edge and land on the following negedge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        PC = 32'h0; Pvalid = 1'b0; Branch = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        rresp = 2'b00; Dready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (Iready !== 1'b1 || arvalid !== 1'b0 || rready !== 1'b0 ||
            Ivalid !== 1'b0 || Ifault !== 1'b0) begin
            $display("FAIL reset_ctrl got=%b%b%b%b%b exp=10000",
                     Iready, arvalid, rready, Ivalid, Ifault);
            failures++;
        end
        checks++;
        if (inst !== 0 || IPC !== 0 || araddr !== 0 || fetch_cnt !== 0) begin
            $display("FAIL reset_data got=%h %h %h %h exp=0",
                     inst, IPC, araddr, fetch_cnt);
            failures++;
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        PC = 32'h8000_0000; Pvalid = 1'b1;
        arready = 1'b1; rvalid = 1'b1;
        rdata = 32'h0000_0413; Dready = 1'b1;
        tick();
        Pvalid = 1'b0;
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h8000_0000 || Iready !== 1'b0) begin
            $display("FAIL basic_ar got=%b %h %b exp=1 80000000 0",
                     arvalid, araddr, Iready);
            failures++;
        end
        tick();
        checks++;
        if (Ivalid !== 1'b0 || rready !== 1'b1) begin
            $display("FAIL basic_r got=%b %b exp=0 1", Ivalid, rready);
            failures++;
        end
        tick();
        checks++;
        if (Ivalid !== 1'b1 || inst !== 32'h0000_0413 ||
            IPC !== 32'h8000_0000 || Ifault !== 1'b0) begin
            $display("FAIL basic_out got=%b %h %h %b exp=1 00000413 80000000 0",
                     Ivalid, inst, IPC, Ifault);
            failures++;
        end
        tick();
        exp_cnt++;
        checks++;
        if (Ivalid !== 1'b0 || fetch_cnt !== exp_cnt || Iready !== 1'b1) begin
            $display("FAIL basic_done got=%b %0d %b exp=0 %0d 1",
                     Ivalid, fetch_cnt, Iready, exp_cnt);
            failures++;
        end
        idle_inputs();
    endtask

    task automatic test_delays();
        PC = 32'h8000_0004; Pvalid = 1'b1;
        tick();
        Pvalid = 1'b0; PC = 32'h1111_1110;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (arvalid !== 1'b1 || araddr !== 32'h8000_0004) begin
                $display("FAIL delay_ar_stable[%0d] got=%b %h exp=1 80000004",
                         i, arvalid, araddr);
                failures++;
            end
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (arvalid !== 1'b0 || rready !== 1'b1 || Ivalid !== 1'b0) begin
                $display("FAIL delay_r_wait[%0d] got=%b %b %b exp=0 1 0",
                         i, arvalid, rready, Ivalid);
                failures++;
            end
            tick();
        end
        rvalid = 1'b1; rdata = 32'h1234_5678;
        tick();
        rvalid = 1'b0; rdata = 32'h0;
        checks++;
        if (Ivalid !== 1'b1 || inst !== 32'h1234_5678 || rready !== 1'b0) begin
            $display("FAIL delay_out got=%b %h %b exp=1 12345678 0",
                     Ivalid, inst, rready);
            failures++;
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (Ivalid !== 1'b1 || inst !== 32'h1234_5678 ||
                IPC !== 32'h8000_0004 || Iready !== 1'b0 || arvalid !== 1'b0) begin
                $display("FAIL stall_hold[%0d] got=%b %h %h %b %b exp=1 12345678 80000004 0 0",
                         i, Ivalid, inst, IPC, Iready, arvalid);
                failures++;
            end
        end
        Dready = 1'b1;
        tick();
        exp_cnt++;
        checks++;
        if (Ivalid !== 1'b0 || fetch_cnt !== exp_cnt) begin
            $display("FAIL stall_done got=%b %0d exp=0 %0d",
                     Ivalid, fetch_cnt, exp_cnt);
            failures++;
        end
        idle_inputs();
    endtask

    task automatic test_branch_r();
        PC = 32'h8000_0008; Pvalid = 1'b1;
        tick();
        Pvalid = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0; Branch = 1'b1;
        tick();
        Branch = 1'b0; rvalid = 1'b1; rdata = 32'hdead_beef;
        checks++;
        if (rready !== 1'b1 || Ivalid !== 1'b0) begin
            $display("FAIL kill_r_hold got=%b %b exp=1 0", rready, Ivalid);
            failures++;
        end
        tick();
        rvalid = 1'b0;
        checks++;
        if (Ivalid !== 1'b0 || Iready !== 1'b1 || rready !== 1'b0 ||
            fetch_cnt !== exp_cnt) begin
            $display("FAIL kill_r got=%b %b %b %0d exp=0 1 0 %0d",
                     Ivalid, Iready, rready, fetch_cnt, exp_cnt);
            failures++;
        end
        PC = 32'h8000_0100; Pvalid = 1'b1;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h0010_0093;
        tick();
        Pvalid = 1'b0;
        tick();
        tick();
        checks++;
        if (Ivalid !== 1'b1 || inst !== 32'h0010_0093 || IPC !== 32'h8000_0100) begin
            $display("FAIL after_kill got=%b %h %h exp=1 00100093 80000100",
                     Ivalid, inst, IPC);
            failures++;
        end
        Dready = 1'b1;
        tick();
        exp_cnt++;
        checks++;
        if (fetch_cnt !== exp_cnt) begin
            $display("FAIL after_kill_cnt got=%0d exp=%0d", fetch_cnt, exp_cnt);
            failures++;
        end
        idle_inputs();
    endtask

    task automatic test_branch_edges();
        PC = 32'h8000_0010; Pvalid = 1'b1;
        tick();
        Pvalid = 1'b0; arready = 1'b1; Branch = 1'b1;
        tick();
        arready = 1'b0; Branch = 1'b0; rvalid = 1'b1; rdata = 32'h5555_aaaa;
        tick();
        rvalid = 1'b0;
        checks++;
        if (Ivalid !== 1'b0 || Iready !== 1'b1 || fetch_cnt !== exp_cnt) begin
            $display("FAIL kill_ar_edge got=%b %b %0d exp=0 1 %0d",
                     Ivalid, Iready, fetch_cnt, exp_cnt);
            failures++;
        end
        PC = 32'h8000_0014; Pvalid = 1'b1;
        arready = 1'b1; rvalid = 1'b1;
        tick();
        Pvalid = 1'b0;
        tick();
        tick();
        Dready = 1'b1; Branch = 1'b1;
        tick();
        Branch = 1'b0; Dready = 1'b0;
        checks++;
        if (Ivalid !== 1'b0 || Iready !== 1'b1 || fetch_cnt !== exp_cnt) begin
            $display("FAIL kill_out got=%b %b %0d exp=0 1 %0d",
                     Ivalid, Iready, fetch_cnt, exp_cnt);
            failures++;
        end
        PC = 32'h8000_0018; Pvalid = 1'b1; Branch = 1'b1;
        tick();
        Pvalid = 1'b0; Branch = 1'b0;
        checks++;
        if (Iready !== 1'b1 || arvalid !== 1'b0 || IPC === 32'h8000_0018) begin
            $display("FAIL branch_idle got=%b %b %h exp=1 0 !80000018",
                     Iready, arvalid, IPC);
            failures++;
        end
        idle_inputs();
    endtask

    task automatic test_faults();
        PC = 32'h8000_0002; Pvalid = 1'b1;
        tick();
        Pvalid = 1'b0;
        checks++;
        if (arvalid !== 1'b0 || Ivalid !== 1'b1 || Ifault !== 1'b1 ||
            inst !== 32'h0 || IPC !== 32'h8000_0002) begin
            $display("FAIL misalign got=%b %b %b %h %h exp=0 1 1 0 80000002",
                     arvalid, Ivalid, Ifault, inst, IPC);
            failures++;
        end
        Dready = 1'b1;
        tick();
        exp_cnt++;
        Dready = 1'b0;
        PC = 32'h8000_0020; Pvalid = 1'b1;
        arready = 1'b1; rvalid = 1'b1;
        rdata = 32'hcafe_f00d; rresp = 2'b10;
        tick();
        Pvalid = 1'b0;
        tick();
        tick();
        checks++;
        if (Ivalid !== 1'b1 || Ifault !== 1'b1 || inst !== 32'hcafe_f00d ||
            fetch_cnt !== exp_cnt) begin
            $display("FAIL rresp_fault got=%b %b %h %0d exp=1 1 cafef00d %0d",
                     Ivalid, Ifault, inst, fetch_cnt, exp_cnt);
            failures++;
        end
        Dready = 1'b1;
        tick();
        exp_cnt++;
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        PC = 32'h8000_0030; Pvalid = 1'b1;
        tick();
        Pvalid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        exp_cnt = 0;
        checks++;
        if (arvalid !== 1'b0 || Iready !== 1'b1 || fetch_cnt !== 0 ||
            araddr !== 0) begin
            $display("FAIL reset_mid got=%b %b %0d %h exp=0 1 0 0",
                     arvalid, Iready, fetch_cnt, araddr);
            failures++;
        end
        @(negedge clk);
        rstn = 1'b1;
        PC = 32'h8000_0040; Pvalid = 1'b1;
        tick();
        Pvalid = 1'b0;
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h8000_0040) begin
            $display("FAIL first_after_reset got=%b %h exp=1 80000040",
                     arvalid, araddr);
            failures++;
        end
        idle_inputs();
    endtask

    initial begin
        rstn = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_basic();
        test_delays();
        test_branch_r();
        test_branch_edges();
        test_faults();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
